// File: rtl/periph_bus_master.sv
// Command-driven master for a simple strobed peripheral bus: single write, single read,
// and poll-until-mask-hit with an attempt limit, each answered by one response beat.
module periph_bus_master #(
  parameter int RD_LATENCY = 1,
  parameter int POLL_MAX   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        p_cs,
  output logic        p_rd,
  output logic        p_wr,
  output logic [4:0]  p_addr,
  output logic [15:0] p_wdata,
  input  logic [31:0] p_rdata
);

  localparam logic [1:0]  OP_WR      = 2'b00;
  localparam logic [1:0]  OP_RD      = 2'b01;
  localparam logic [1:0]  OP_RSV     = 2'b11;
  localparam logic [1:0]  LAT_W      = 2'(RD_LATENCY);
  localparam logic [15:0] POLL_MAX_W = 16'(POLL_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_CHECK,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic        r_cs;
  logic        r_rd;
  logic        r_wr;
  logic [4:0]  r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_op;
  logic [31:0] r_mask;
  logic [31:0] r_cap;
  logic [15:0] r_attempt;
  logic [1:0]  r_wcnt;
  logic        w_hit;

  function automatic logic poll_hit(input logic [31:0] data, input logic [31:0] mask);
    return |(data & mask);
  endfunction

  assign w_hit = poll_hit(r_cap, r_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_cs        <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= 5'd0;
      r_wdata     <= 16'd0;
      r_op        <= OP_WR;
      r_attempt   <= 16'd0;
      r_wcnt      <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_op        <= cmd_op;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_mask      <= cmd_mask;
            r_attempt   <= 16'd1;
            r_cmd_ready <= 1'b0;
            if (cmd_op == OP_RSV) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'd0;
            end else begin
              r_state <= S_STROBE;
              r_cs    <= 1'b1;
              r_wr    <= (cmd_op == OP_WR);
              r_rd    <= (cmd_op != OP_WR);
            end
          end
        end

        S_STROBE: begin
          r_cs <= 1'b0;
          r_rd <= 1'b0;
          r_wr <= 1'b0;
          if (r_op == OP_WR) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
          end else begin
            r_state <= S_WAIT;
            r_wcnt  <= 2'd1;
          end
        end

        // p_rdata is valid during the last WAIT cycle; sample it on that edge.
        S_WAIT: begin
          if (r_wcnt == LAT_W) begin
            if (r_op == OP_RD) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_rdata <= p_rdata;
            end else begin
              r_state <= S_CHECK;
              r_cap   <= p_rdata;
            end
          end else begin
            r_wcnt <= r_wcnt + 2'd1;
          end
        end

        S_CHECK: begin
          if (w_hit) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_cap;
          end else if (r_attempt == POLL_MAX_W) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= r_cap;
          end else begin
            r_attempt <= r_attempt + 16'd1;
            r_state   <= S_STROBE;
            r_cs      <= 1'b1;
            r_rd      <= 1'b1;
          end
        end

        // cmd_ready rises only after the handshake edge, so no same-edge re-accept.
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_cs        <= 1'b0;
          r_rd        <= 1'b0;
          r_wr        <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign p_cs      = r_cs;
  assign p_rd      = r_rd;
  assign p_wr      = r_wr;
  assign p_addr    = r_addr;
  assign p_wdata   = r_wdata;

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed and randomized bench for periph_bus_master with a registered peripheral model
// and a transaction-level expectation of data, error, strobe counts and latency.
module tb_periph_bus_master;

  localparam int RD_LATENCY = 1;
  localparam int POLL_MAX   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        p_cs;
  logic        p_rd;
  logic        p_wr;
  logic [4:0]  p_addr;
  logic [15:0] p_wdata;
  logic [31:0] p_rdata;

  always #5 clk = ~clk;

  periph_bus_master #(
    .RD_LATENCY(RD_LATENCY),
    .POLL_MAX  (POLL_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_mask (cmd_mask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .p_cs     (p_cs),
    .p_rd     (p_rd),
    .p_wr     (p_wr),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata)
  );

  // Peripheral: returns queued values (or a default) RD_LATENCY cycles after a read strobe,
  // and random garbage otherwise so a mistimed capture is visible.
  logic [31:0] rd_q[$];
  logic [31:0] rd_default;
  logic [31:0] pipe [RD_LATENCY];
  int          rd_cnt;
  int          wr_cnt;
  int          bad_cnt;
  logic [4:0]  last_addr;
  logic [15:0] last_wdata;

  always @(posedge clk) begin
    logic [31:0] v;
    v = $urandom;
    if (p_cs === 1'b1 && p_rd === 1'b1 && p_wr === 1'b0) begin
      rd_cnt++;
      last_addr = p_addr;
      if (rd_q.size() > 0) v = rd_q.pop_front();
      else v = rd_default;
    end else if (p_cs === 1'b1 && p_wr === 1'b1 && p_rd === 1'b0) begin
      wr_cnt++;
      last_addr  = p_addr;
      last_wdata = p_wdata;
    end else if (p_cs === 1'b1 || p_rd === 1'b1 || p_wr === 1'b1) begin
      bad_cnt++;
    end
    pipe[0] <= v;
    for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign p_rdata = pipe[RD_LATENCY-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [15:0] wd,
                         input logic [31:0] mask, input int hold,
                         output int lat, output logic [31:0] rd, output logic er);
    int g;
    @(negedge clk);
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_mask  = mask;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_wdata = 16'($urandom);
    cmd_mask  = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid !== 1'b1 && lat < 500);
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_err", 32'(rsp_err), 32'(er));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_done", 32'(rsp_valid), 32'd0);
    check("ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          r0;
    int          w0;
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [15:0] wd;
    logic [31:0] mask;
    logic [31:0] v;
    logic [31:0] vals[$];
    int          hold;
    int          hitk;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
    logic [31:0] exp_rd;
    logic        exp_err;

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_addr   = 5'd0;
    cmd_wdata  = 16'd0;
    cmd_mask   = 32'd0;
    rsp_ready  = 1'b1;
    rd_default = 32'd0;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_strobes", {29'd0, p_cs, p_rd, p_wr}, 32'd0);
    check("rst_p_addr", 32'(p_addr), 32'd0);
    check("rst_p_wdata", 32'(p_wdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed write
    r0 = rd_cnt; w0 = wr_cnt;
    run_cmd(2'b00, 5'd3, 16'h0019, 32'd0, 0, lat, rd, er);
    check("wr_latency", 32'(lat), 32'd2);
    check("wr_err", 32'(er), 32'd0);
    check("wr_rdata", rd, 32'd0);
    check("wr_strobes", 32'(wr_cnt - w0), 32'd1);
    check("wr_no_rd", 32'(rd_cnt - r0), 32'd0);
    check("wr_addr", 32'(last_addr), 32'd3);
    check("wr_wdata", 32'(last_wdata), 32'h0019);
    check("wr_addr_held", 32'(p_addr), 32'd3);
    check("wr_wdata_held", 32'(p_wdata), 32'h0019);

    // Directed read
    r0 = rd_cnt; w0 = wr_cnt;
    rd_q.delete();
    rd_q.push_back(32'h0000_0005);
    run_cmd(2'b01, 5'd1, 16'h0000, 32'd0, 0, lat, rd, er);
    check("rd_latency", 32'(lat), 32'(2 + RD_LATENCY));
    check("rd_rdata", rd, 32'h0000_0005);
    check("rd_err", 32'(er), 32'd0);
    check("rd_strobes", 32'(rd_cnt - r0), 32'd1);
    check("rd_addr", 32'(last_addr), 32'd1);

    // Poll hitting on the third attempt
    r0 = rd_cnt;
    rd_q.delete();
    rd_q.push_back(32'd0); rd_q.push_back(32'd0); rd_q.push_back(32'd1);
    run_cmd(2'b10, 5'd4, 16'h0000, 32'h1, 0, lat, rd, er);
    check("poll_hit_strobes", 32'(rd_cnt - r0), 32'd3);
    check("poll_hit_rdata", rd, 32'h1);
    check("poll_hit_err", 32'(er), 32'd0);
    check("poll_hit_latency", 32'(lat), 32'(3 * (2 + RD_LATENCY) + 1));

    // Poll timeout
    r0 = rd_cnt;
    rd_q.delete();
    rd_default = 32'h7FFF_FFFF;
    run_cmd(2'b10, 5'd5, 16'h0000, 32'h8000_0000, 0, lat, rd, er);
    check("poll_to_strobes", 32'(rd_cnt - r0), 32'(POLL_MAX));
    check("poll_to_err", 32'(er), 32'd1);
    check("poll_to_rdata", rd, 32'h7FFF_FFFF);
    check("poll_to_latency", 32'(lat), 32'(POLL_MAX * (2 + RD_LATENCY) + 1));
    rd_default = 32'd0;

    // Reserved op with back-pressure
    r0 = rd_cnt; w0 = wr_cnt;
    run_cmd(2'b11, 5'd9, 16'h1234, 32'd0, 5, lat, rd, er);
    check("rsv_latency", 32'(lat), 32'd1);
    check("rsv_err", 32'(er), 32'd1);
    check("rsv_rdata", rd, 32'd0);
    check("rsv_no_strobes", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);

    // Reset during poll WAIT
    rd_q.delete();
    @(negedge clk);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_addr  = 5'd7;
    cmd_mask  = 32'd0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rstw_strobe", {30'd0, p_cs, p_rd}, 32'd3);
    @(negedge clk);
    check("rstw_in_wait", {29'd0, p_cs, p_rd, rsp_valid}, 32'd0);
    r0 = rd_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstw_strobes", {29'd0, p_cs, p_rd, p_wr}, 32'd0);
    check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstw_p_addr", 32'(p_addr), 32'd0);
    repeat (6) @(negedge clk);
    check("rstw_no_more_rd", 32'(rd_cnt - r0), 32'd0);
    check("rstw_still_idle", 32'(rsp_valid), 32'd0);
    r0 = rd_cnt;
    rd_q.push_back(32'h1234_5678);
    run_cmd(2'b01, 5'd2, 16'h0000, 32'd0, 0, lat, rd, er);
    check("rstw_rd_rdata", rd, 32'h1234_5678);
    check("rstw_rd_latency", 32'(lat), 32'(2 + RD_LATENCY));
    check("rstw_rd_strobes", 32'(rd_cnt - r0), 32'd1);

    // Reset discards a pending response
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rstr_pending", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstr_valid", 32'(rsp_valid), 32'd0);
    check("rstr_err", 32'(rsp_err), 32'd0);
    check("rstr_cmd_ready", 32'(cmd_ready), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);

    // Randomized commands against the transaction model
    for (int t = 0; t < 40; t++) begin
      op   = 2'($urandom_range(0, 3));
      addr = 5'($urandom);
      wd   = 16'($urandom);
      hold = int'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       mask = 32'd0;
        1:       mask = 32'd1 << $urandom_range(0, 31);
        default: mask = $urandom;
      endcase
      rd_q.delete();
      vals.delete();
      exp_nrd = 0;
      exp_nwr = 0;
      exp_rd  = 32'd0;
      exp_err = 1'b0;
      case (op)
        2'b00: begin
          exp_lat = 2;
          exp_nwr = 1;
        end
        2'b01: begin
          v = $urandom;
          rd_q.push_back(v);
          exp_lat = 2 + RD_LATENCY;
          exp_rd  = v;
          exp_nrd = 1;
        end
        2'b10: begin
          hitk = int'($urandom_range(1, POLL_MAX + 1));
          for (int a = 1; a <= POLL_MAX; a++) begin
            v = $urandom;
            if (a < hitk) v = v & ~mask;
            else if (a == hitk) v = v | mask;
            vals.push_back(v);
            rd_q.push_back(v);
          end
          exp_err = 1'b1;
          foreach (vals[k]) begin
            exp_nrd = k + 1;
            exp_rd  = vals[k];
            if ((vals[k] & mask) != 32'd0) begin
              exp_err = 1'b0;
              break;
            end
          end
          exp_lat = exp_nrd * (2 + RD_LATENCY) + 1;
        end
        default: begin
          exp_lat = 1;
          exp_err = 1'b1;
        end
      endcase
      r0 = rd_cnt; w0 = wr_cnt;
      run_cmd(op, addr, wd, mask, hold, lat, rd, er);
      check("rnd_latency", 32'(lat), 32'(exp_lat));
      check("rnd_rdata", rd, exp_rd);
      check("rnd_err", 32'(er), 32'(exp_err));
      check("rnd_rd_strobes", 32'(rd_cnt - r0), 32'(exp_nrd));
      check("rnd_wr_strobes", 32'(wr_cnt - w0), 32'(exp_nwr));
      if (op == 2'b00) check("rnd_wr_wdata", 32'(last_wdata), 32'(wd));
      if (op != 2'b11) check("rnd_addr", 32'(last_addr), 32'(addr));
    end

    check("bad_strobe_combos", 32'(bad_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
